// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch stage.
//  fetch_state_t : fetch FSM states
//  fetch_entry_t : one prefetch FIFO entry {pc, word}
//  align_word()  : clear the byte-offset bits of an address
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // no request outstanding
    F_REQ  = 2'd1,  // live request outstanding
    F_DROP = 2'd2   // request outstanding whose data is stale (redirected)
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Purpose: bundles the fetch stage's redirect, instruction-memory and decode-side signals.
//  master : the fetch unit (drives imem_req/imem_addr and the inst_* head outputs)
//  slave  : the surrounding core / memory (drives redirect, imem_ack/rdata, inst_ready)
interface instr_fetch_unit_if
  import fetch_pkg::*;
();

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic              misalign_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_word, inst_pc, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_word, inst_pc, misalign_err
  );

endinterface

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry prefetch FIFO of {pc, word} entries.
//  clk, rst  : clock, async active-high reset
//  push_i    : write wdata_i (caller guarantees a free slot)
//  pop_i     : drop head entry (ignored when empty)
//  flush_i   : synchronous clear; wins over push/pop
//  head_o    : head entry while non-empty, otherwise the last head presented
//  count_o   : occupancy, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  fetch_entry_t       wdata_i,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             hold_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic                     do_push_c;
  logic                     do_pop_c;

  assign do_push_c = push_i && !flush_i;
  assign do_pop_c  = pop_i && !flush_i && (count_q != '0);

  // Storage array; contents only matter where the pointers say they do.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push_c && !do_pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push_c && do_pop_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Remembers the head last shown so the outputs hold steady while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (count_q != '0) begin
      hold_q <= mem_q[rd_ptr_q];
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch stage. Owns the PC, issues single outstanding word reads to instruction
//  memory, buffers returned words with their PC and hands them to decode; redirects flush
//  the stage and restart fetch at the (word-aligned) target.
//  clk, rst : clock, async active-high reset
//  bus      : redirect_valid/redirect_pc, imem_req/addr/ack/rdata,
//             inst_valid/ready/word/pc, misalign_err
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               misalign_q, misalign_d;

  logic               push_c;
  logic               pop_c;
  logic [CNT_W-1:0]   count_c;
  logic [CNT_W-1:0]   count_next_c;
  fetch_entry_t       head_c;
  fetch_entry_t       wdata_c;

  assign wdata_c = '{pc: fetch_pc_q, word: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (bus.redirect_valid),
    .wdata_i (wdata_c),
    .head_o  (head_c),
    .count_o (count_c)
  );

  // State, PC and misalign-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic; a redirect overrides everything else this cycle.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    misalign_d   = 1'b0;
    push_c       = (state_q == F_REQ) && bus.imem_ack && !bus.redirect_valid;
    pop_c        = (count_c != '0) && bus.inst_ready && !bus.redirect_valid;
    count_next_c = count_c;
    if (push_c && !pop_c) begin
      count_next_c = count_c + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_next_c = count_c - CNT_W'(1);
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      misalign_d = (bus.redirect_pc[1:0] != 2'b00);
      unique case (state_q)
        F_IDLE:  state_d = F_REQ;
        // An ack landing with the redirect retires the old request; otherwise it is still in flight.
        F_REQ:   state_d = bus.imem_ack ? F_REQ : F_DROP;
        F_DROP:  state_d = bus.imem_ack ? F_REQ : F_DROP;
        default: state_d = F_IDLE;
      endcase
    end else begin
      unique case (state_q)
        F_IDLE: begin
          if (count_next_c < CNT_W'(DEPTH)) begin
            state_d = F_REQ;
          end
        end
        F_REQ: begin
          if (bus.imem_ack) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            state_d    = (count_next_c < CNT_W'(DEPTH)) ? F_REQ : F_IDLE;
          end
        end
        F_DROP: begin
          if (bus.imem_ack) begin
            state_d = F_REQ;
          end
        end
        default: state_d = F_IDLE;
      endcase
    end
  end

  assign bus.imem_req     = (state_q != F_IDLE);
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.inst_valid   = (count_c != '0);
  assign bus.inst_word    = head_c.word;
  assign bus.inst_pc      = head_c.pc;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder with programmable latency, a decode-stream
// model (expected PC sequence restarting at each redirect) and directed + random scenarios.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory responder: acks after cur_lat cycles; data is a function of the address the
  // request was issued with, so stale returns are distinguishable.
  int unsigned lat_max  = 0;
  bit          lat_rand = 1'b0;
  logic        force_ack = 1'b0;
  int unsigned wait_cnt;
  int unsigned cur_lat;
  logic        busy;
  logic [31:0] lat_addr;

  assign bus.imem_ack   = force_ack | (bus.imem_req && (wait_cnt >= cur_lat));
  assign bus.imem_rdata = busy ? (lat_addr ^ KEY) : (bus.imem_addr ^ KEY);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      busy     <= 1'b0;
      lat_addr <= '0;
      cur_lat  <= lat_max;
    end else if (bus.imem_ack || !bus.imem_req) begin
      wait_cnt <= 0;
      busy     <= 1'b0;
      cur_lat  <= lat_rand ? $urandom_range(lat_max, 0) : lat_max;
    end else begin
      wait_cnt <= wait_cnt + 1;
      if (!busy) begin
        busy     <= 1'b1;
        lat_addr <= bus.imem_addr;
      end
    end
  end

  int          vectors = 0;
  int          errors  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] exp_pc;
  logic        exp_mis;

  // One clock: at the negedge, check the decode stream against the model, then return 1 after posedge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      vectors++;
      if (bus.misalign_err !== exp_mis) begin
        errors++;
        $display("FAIL misalign_err: got %b expected %b at %0t", bus.misalign_err, exp_mis, $time);
      end
      if (bus.redirect_valid) begin
        exp_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
        exp_mis = (bus.redirect_pc[1:0] != 2'b00);
      end else begin
        exp_mis = 1'b0;
        if (bus.inst_valid && bus.inst_ready) begin
          vectors++;
          if (bus.inst_pc !== exp_pc || bus.inst_word !== (exp_pc ^ KEY)) begin
            errors++;
            $display("FAIL stream: got pc %h word %h expected pc %h word %h at %0t",
                     bus.inst_pc, bus.inst_word, exp_pc, exp_pc ^ KEY, $time);
          end
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0;
    exp_mis = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect_pc = pc;
    bus.redirect_valid = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
    vectors++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid); end
    vectors++; if (bus.inst_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h expected 0", bus.inst_word); end
    vectors++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.inst_pc); end
    vectors++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", bus.misalign_err); end
    rst = 1'b0;
    exp_pc = 32'h0;
    exp_mis = 1'b0;
    mon_en = 1'b1;
    tick();
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req %b addr %h expected 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a_exp = 32'h0;
    int nvalid = 0;
    lat_max = 0; lat_rand = 1'b0;
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.imem_req && bus.imem_ack) begin
        vectors++;
        if (bus.imem_addr !== a_exp) begin
          errors++; $display("FAIL stream_addr: got %h expected %h", bus.imem_addr, a_exp);
        end
        a_exp = a_exp + 32'd4;
      end
      if (bus.inst_valid) nvalid++;
    end
    vectors++;
    if (nvalid != 19) begin errors++; $display("FAIL stream_rate: got %0d valid cycles expected 19", nvalid); end
  endtask

  task automatic test_backpressure();
    int nack = 0;
    lat_max = 0; lat_rand = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.imem_req && bus.imem_ack) nack++;
    end
    vectors++; if (nack != 4) begin errors++; $display("FAIL bp_acks: got %0d expected 4", nack); end
    vectors++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_word !== KEY) begin
      errors++; $display("FAIL bp_head: got v%b pc %h word %h expected v1 pc 0 word %h", bus.inst_valid, bus.inst_pc, bus.inst_word, KEY);
    end
    bus.inst_ready = 1'b1;
    tick();
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
      errors++; $display("FAIL bp_resume: got req %b addr %h expected 1 00000010", bus.imem_req, bus.imem_addr);
    end
    repeat (8) tick();
  endtask

  task automatic test_drop();
    bit seen = 1'b0;
    lat_max = 3; lat_rand = 1'b0;
    do_reset();
    bus.inst_ready = 1'b1;
    tick();
    do_redirect(32'h24);
    vectors++; if (dut.state_q !== F_DROP) begin errors++; $display("FAIL drop_state: got %0d expected %0d", dut.state_q, F_DROP); end
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
      errors++; $display("FAIL drop_addr: got req %b addr %h expected 1 00000024", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = bus.inst_valid;
    end
    vectors++; if (!seen || bus.inst_pc !== 32'h24 || bus.inst_word !== (32'h24 ^ KEY)) begin
      errors++; $display("FAIL drop_first: got v%b pc %h word %h expected v1 pc 00000024", seen, bus.inst_pc, bus.inst_word);
    end
    repeat (10) tick();
  endtask

  task automatic test_redirect_ack();
    lat_max = 0; lat_rand = 1'b0;
    do_reset();
    repeat (3) tick();
    vectors++; if (!(bus.imem_req && bus.imem_ack) || bus.inst_valid !== 1'b1) begin
      errors++; $display("FAIL ra_setup: got req %b ack %b valid %b expected 1 1 1", bus.imem_req, bus.imem_ack, bus.inst_valid);
    end
    do_redirect(32'h26);
    vectors++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL ra_mis: got %b expected 1", bus.misalign_err); end
    vectors++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: got valid %b expected 0", bus.inst_valid); end
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
      errors++; $display("FAIL ra_addr: got req %b addr %h expected 1 00000024", bus.imem_req, bus.imem_addr);
    end
    tick();
    vectors++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL ra_mis_once: got %b expected 0", bus.misalign_err); end
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h24) begin
      errors++; $display("FAIL ra_next: got v%b pc %h expected v1 pc 00000024", bus.inst_valid, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    lat_max = 0; lat_rand = 1'b0;
    bus.inst_ready = 1'b1;
    do_redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !seen; i++) begin
      seen = bus.inst_valid;
      if (!seen) tick();
    end
    vectors++; if (!seen || bus.inst_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got v%b pc %h expected v1 pc fffffffc", seen, bus.inst_pc);
    end
    tick();
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: got v%b pc %h expected v1 pc 00000000", bus.inst_valid, bus.inst_pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    bit seen = 1'b0;
    lat_max = 2; lat_rand = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      hit = bus.inst_valid && bus.imem_req && (dut.state_q == F_REQ);
    end
    vectors++; if (!hit) begin errors++; $display("FAIL ar_setup: got no F_REQ with inst_valid expected one"); end
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    force_ack = 1'b1;
    #1;
    vectors++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 ||
                   bus.inst_word !== 32'h0 || bus.inst_pc !== 32'h0 || bus.misalign_err !== 1'b0) begin
      errors++; $display("FAIL ar_async: got req %b addr %h v%b word %h pc %h mis %b expected all zero",
                         bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst_word, bus.inst_pc, bus.misalign_err);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.inst_valid !== 1'b0 || dut.state_q !== F_IDLE) begin
      errors++; $display("FAIL ar_hold: got v%b state %0d expected v0 state %0d", bus.inst_valid, dut.state_q, F_IDLE);
    end
    rst = 1'b0;
    exp_pc = 32'h0;
    exp_mis = 1'b0;
    mon_en = 1'b1;
    tick();
    force_ack = 1'b0;
    vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL ar_idle_ack: got v%b addr %h expected v0 addr 0", bus.inst_valid, bus.imem_addr);
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.inst_valid;
    end
    vectors++; if (!seen || bus.inst_pc !== 32'h0) begin
      errors++; $display("FAIL ar_restart: got v%b pc %h expected v1 pc 0", seen, bus.inst_pc);
    end
    repeat (6) tick();
  endtask

  task automatic test_random();
    lat_max = 3; lat_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) begin
        bus.redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
        bus.redirect_valid = 1'b1;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
      vectors++;
      if (bus.imem_req === 1'b0 && dut.state_q !== F_IDLE) begin
        errors++; $display("FAIL rand_req: got req 0 in state %0d expected req 1", dut.state_q);
      end
    end
    bus.redirect_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
